shift_right_iter: RTL
=====================

// Module: shift_right_iter
// PURPOSE
//  Multi-cycle right shifter/rotator for the ALU; complements the combinational left shift/rotate unit.
//  Performs logical right, arithmetic right and rotate right of sr1 by a SHW-bit amount.
//  Runs one barrel stage per clock (stage k shifts by 2^k when shift[k]=1), trading latency for area.
//  Uses a start/busy/done handshake with the ALU control FSM.
// PARAMETERS
//  WIDTH  32  operand width; must be a power of 2
//  SHW    6   shift-amount width, = log2(WIDTH)+1; the top bit selects a shift of WIDTH
// PORTS
//  clk     in   1      single clock; all state updates on posedge clk
//  rst     in   1      synchronous reset, active-high
//  start   in   1      request; accepted only when busy=0
//  op      in   2      00 LSR, 01 ASR, 10 ROR, 11 reserved (executes as LSR)
//  sr1     in   WIDTH  operand; sampled on the accept edge only
//  shift   in   SHW    shift amount 0..2^SHW-1; sampled on the accept edge only
//  result  out  WIDTH  shifted value; valid while done=1, held until the next accept
//  busy    out  1      1 in RUN state
//  done    out  1      one-cycle completion pulse
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, result=0, internal cnt=0.
//  States: IDLE, RUN, DONE. busy=1 only in RUN; done=1 only in DONE.
//  Accept: start=1 in IDLE or DONE. On that edge: load data reg <- sr1, amt <- shift, op, cnt <- 0; go to RUN.
//  RUN edge: if amt[cnt]=1, apply stage cnt to the data reg; cnt++.
//   If cnt==SHW-1, go to DONE.
//  DONE: done=1 for exactly one cycle.
//   If start=1, accept (back-to-back); otherwise return to IDLE.
//  Latency: start accepted at edge T -> RUN during cycles T+1..T+SHW -> done=1 in cycle T+SHW+1 (T+7 by default).
//  Stage k by d=2^k, d<WIDTH:
//   LSR fills zeros; ASR fills copies of the captured sr1[WIDTH-1]; ROR sets data = {data[d-1:0], data[WIDTH-1:d]}.
//  Stage with d=WIDTH (k=SHW-1): LSR -> 0; ASR -> all bits = sign; ROR -> unchanged (amount is effectively mod WIDTH).
//  Net result: LSR/ASR saturate for amounts >= WIDTH; ROR rotates by shift mod WIDTH.
//  The sign bit comes from the captured operand, not from the partially shifted data.
//  start while busy=1 is ignored; no queueing. sr1/shift/op changes after accept have no effect.
//  rst mid-operation: the cycle after the rst edge shows IDLE, busy=0, done=0, result=0.
//   No done pulse is issued for the aborted request.
//  rst and start on the same edge: rst wins; the request is dropped.
//  result changes only on RUN edges and on reset; it is stable in DONE and in IDLE.
// CONFIGURATION
//  SHIFT_R_EARLY_EXIT_EN defined:
//   - At accept, if shift==0, go straight to DONE: done in T+1, result=sr1.
//   - In RUN, after applying stage cnt, go to DONE when amt[SHW-1:cnt+1]==0.
//   - Latency = T + (index of highest set shift bit) + 2.
//  SHIFT_R_EARLY_EXIT_EN undefined: fixed latency of SHW+1 cycles for every amount, including 0.
//  result values are identical in both builds.
// TESTING
//  1. LSR sr1=0x80000000 shift=4, start at T -> busy T+1..T+6, done=1 only in T+7, result=0x08000000.
//  2. ASR sr1=0x80000000 shift=4 -> 0xF8000000.
//     ASR shift=40 -> 0xFFFFFFFF. ASR sr1=0x7FFFFFFF shift=63 -> 0x00000000.
//  3. ROR sr1=0x0000000F shift=4 -> 0xF0000000. ROR shift=36 -> 0xF0000000. ROR shift=32 -> 0x0000000F.
//  4. start held high during RUN with changing sr1 -> result is from the first operand only.
//     start=1 in the DONE cycle -> new op accepted, done again 7 cycles later. op=11 -> LSR result.
//  5. rst=1 at T+3 of a running op -> from T+4 busy=0, done=0, result=0.
//     No done pulse follows. The next start completes normally.
//  6. With SHIFT_R_EARLY_EXIT_EN: shift=0 -> done T+1; shift=1 -> done T+2; shift=33 -> done T+7.
//     All results equal the default build.

Source files
------------

// File: rtl/shift_right_iter_if.sv
// Request/response bundle between the ALU control FSM and the iterative right shifter.
// start is accepted whenever busy=0; done pulses one cycle with result valid, result holds until next accept.
interface shift_right_iter_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 6
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] sr1;
    logic [SHW-1:0]   shift;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

    modport master (
        output start, op, sr1, shift,
        input  result, busy, done
    );

    modport slave (
        input  start, op, sr1, shift,
        output result, busy, done
    );
endinterface

// File: rtl/shift_right_iter.sv
// Multi-cycle LSR/ASR/ROR unit: one barrel stage per clock, start/busy/done handshake.
// Optional SHIFT_R_EARLY_EXIT_EN: finish as soon as no higher shift-amount bits remain.
module shift_right_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 6
) (
    input  logic            clk,
    input  logic            rst,
    shift_right_iter_if.slave bus,
    output logic [1:0]      dbg_state_o
);
    localparam int CW = $clog2(SHW);
    localparam logic [CW-1:0] LAST = CW'(SHW - 1);

    localparam logic [1:0] OP_ASR = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [SHW-1:0]   amt_q, amt_d;
    logic [1:0]       op_q, op_d;
    logic             sign_q, sign_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy, done, accept;

    // Stage k shifts by 2^k; the top stage (2^k == WIDTH) saturates LSR/ASR and leaves ROR alone.
    function automatic logic [WIDTH-1:0] stage_f(
        input logic [WIDTH-1:0] v,
        input logic [CW-1:0]    k,
        input logic [1:0]       opc,
        input logic             sgn
    );
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] fill;
        logic [WIDTH-1:0] r;
        int unsigned      d;
        ones = '1;
        d    = 32'd1 << k;
        fill = sgn ? ~(ones >> d) : '0;
        r    = '0;
        if (k == LAST) begin
            case (opc)
                OP_ASR:  r = {WIDTH{sgn}};
                OP_ROR:  r = v;
                default: r = '0;
            endcase
        end else begin
            case (opc)
                OP_ASR:  r = (v >> d) | fill;
                OP_ROR:  r = (v >> d) | (v << (WIDTH - d));
                default: r = v >> d;
            endcase
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            data_q   <= '0;
            result_q <= '0;
            amt_q    <= '0;
            op_q     <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            result_q <= result_d;
            amt_q    <= amt_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        result_d = result_q;
        amt_d    = amt_q;
        op_d     = op_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        busy     = 1'b0;
        done     = 1'b0;
        accept   = bus.start && (state_q != S_RUN);

        case (state_q)
            S_RUN: begin
                busy = 1'b1;
                if (amt_q[cnt_q]) begin
                    data_d = stage_f(data_q, cnt_q, op_q, sign_q);
                end
                result_d = data_d;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end
`ifdef SHIFT_R_EARLY_EXIT_EN
                else if ((amt_q >> (cnt_q + 1'b1)) == '0) begin
                    state_d = S_DONE;
                end
`endif
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: ;
        endcase

        // Accept overrides the DONE->IDLE return so back-to-back requests lose no cycle.
        if (accept) begin
            data_d  = bus.sr1;
            amt_d   = bus.shift;
            op_d    = bus.op;
            sign_d  = bus.sr1[WIDTH-1];
            cnt_d   = '0;
            state_d = S_RUN;
`ifdef SHIFT_R_EARLY_EXIT_EN
            if (bus.shift == '0) begin
                state_d  = S_DONE;
                result_d = bus.sr1;
            end
`endif
        end
    end

    assign bus.result  = result_q;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign dbg_state_o = state_q;
endmodule
